// File: rtl/vga_system_ram_dual_if.sv
// Avalon-MM slave bus bundle for one port of vga_system_ram_dual.
// The master drives the request side; the RAM drives read data, valid and stall.
interface vga_system_ram_dual_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [BE_WIDTH-1:0]   byteenable;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/vga_system_ram_dual.sv
// True dual-port RAM with two Avalon-MM slave ports sharing one clock.
// s1 wins same-address write collisions; s2 is stalled one cycle via waitrequest.
// Cross-port read-during-write returns old data. freeze discards writes.
// Optional feature macro RAM_OUTREG_EN: adds an output register stage (latency 2,
// readdata zeroed when not valid). Undefined: latency 1, readdata from RAM q.
module vga_system_ram_dual #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter     INIT_FILE  = "vga_system_ram_dual.hex"
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clken,
  input  logic                   freeze,
  vga_system_ram_dual_if.slave   s1,
  vga_system_ram_dual_if.slave   s2
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  // The power-up image is attached to the memory by the implementation flow;
  // reset never reloads it, so no logic here depends on it.
  if (INIT_FILE != "") begin : g_init_image
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Per-port request views (index 0 = s1, 1 = s2)
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [BE_WIDTH-1:0]   be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [1:0]            rd;
  logic [1:0]            wr;
  logic [1:0]            req;
  logic [1:0]            acc;
  logic [1:0]            we;
  logic [1:0]            re;
  logic                  collide;

  // Reset release synchroniser
  logic [1:0] rst_sync_q;
  logic       rst_ok;

  // Read pipeline stage 1 (RAM q)
  logic [1:0]            rvld1_q;
  logic [1:0]            rvld1_d;
  logic [DATA_WIDTH-1:0] rdat1_q [2];

  // Port outputs
  logic [1:0]            out_vld;
  logic [DATA_WIDTH-1:0] out_dat [2];

  // Two-flop release: asserts asynchronously, releases on the second edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_ok = rst_sync_q[1];

  // Collision detect, acceptance and per-port write/read enables
  always_comb begin
    addr[0]  = s1.address;    addr[1]  = s2.address;
    be[0]    = s1.byteenable; be[1]    = s2.byteenable;
    wdata[0] = s1.writedata;  wdata[1] = s2.writedata;
    rd       = {s2.read,  s1.read};
    wr       = {s2.write, s1.write};
    collide  = s1.chipselect & s1.write & s2.chipselect & s2.write &
               (s1.address == s2.address);
    req[0]   = s1.chipselect & (s1.read | s1.write);
    req[1]   = s2.chipselect & (s2.read | s2.write) & ~collide;
    acc      = '0;
    we       = '0;
    re       = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      acc[p] = req[p] & clken & rst_ok;
      // A simultaneous read on a writing port is dropped, so no same-port RDW
      we[p]  = acc[p] & wr[p] & ~freeze;
      re[p]  = acc[p] & rd[p] & ~wr[p];
    end
  end

  // Byte-lane writes; s2 never targets s1's address in the same cycle
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (we[p] && be[p][b]) mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
      end
    end
  end

  // Stage-1 valid next state: hold while clock enable is low
  always_comb begin
    rvld1_d = rvld1_q;
    if (clken) rvld1_d = re;
  end

  // Stage-1 registers: synchronous RAM read (old data on cross-port RDW)
  always_ff @(posedge clk or negedge rst_ok) begin
    if (!rst_ok) begin
      rvld1_q <= '0;
      for (int unsigned p = 0; p < 2; p++) rdat1_q[p] <= '0;
    end else begin
      rvld1_q <= rvld1_d;
      for (int unsigned p = 0; p < 2; p++) begin
        if (re[p]) rdat1_q[p] <= mem[addr[p]];
      end
    end
  end

`ifdef RAM_OUTREG_EN
  logic [1:0]            rvld2_q;
  logic [1:0]            rvld2_d;
  logic [DATA_WIDTH-1:0] rdat2_q [2];
  logic [DATA_WIDTH-1:0] rdat2_d [2];

  // Stage-2 next state: advance on enable, data forced to zero unless valid
  always_comb begin
    rvld2_d = rvld2_q;
    for (int unsigned p = 0; p < 2; p++) rdat2_d[p] = rdat2_q[p];
    if (clken) begin
      rvld2_d = rvld1_q;
      for (int unsigned p = 0; p < 2; p++) rdat2_d[p] = rvld1_q[p] ? rdat1_q[p] : '0;
    end
  end

  // Stage-2 output registers
  always_ff @(posedge clk or negedge rst_ok) begin
    if (!rst_ok) begin
      rvld2_q <= '0;
      for (int unsigned p = 0; p < 2; p++) rdat2_q[p] <= '0;
    end else begin
      rvld2_q <= rvld2_d;
      for (int unsigned p = 0; p < 2; p++) rdat2_q[p] <= rdat2_d[p];
    end
  end

  // Outputs from the output register stage
  always_comb begin
    out_vld = rvld2_q;
    for (int unsigned p = 0; p < 2; p++) out_dat[p] = rdat2_q[p];
  end
`else
  // Outputs straight from the RAM q stage
  always_comb begin
    out_vld = rvld1_q;
    for (int unsigned p = 0; p < 2; p++) out_dat[p] = rdat1_q[p];
  end
`endif

  assign s1.readdata      = out_dat[0];
  assign s1.readdatavalid = out_vld[0];
  assign s1.waitrequest   = 1'b0;
  assign s2.readdata      = out_dat[1];
  assign s2.readdatavalid = out_vld[1];
  assign s2.waitrequest   = collide;

endmodule

// File: tb/tb_vga_system_ram_dual.sv
// Scoreboard bench for vga_system_ram_dual: read expectations are pushed from a
// reference memory when a read is accepted and popped when readdatavalid appears.
module tb_vga_system_ram_dual;

`ifdef RAM_OUTREG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int unsigned ecnt;
  } exp_t;

  logic clk;
  logic reset_n;
  logic clken;
  logic freeze;

  vga_system_ram_dual_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) s1_bus ();
  vga_system_ram_dual_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) s2_bus ();

  vga_system_ram_dual #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .INIT_FILE ("vga_system_ram_dual.hex")
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .clken  (clken),
    .freeze (freeze),
    .s1     (s1_bus),
    .s2     (s2_bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned ecnt     = 0;
  int unsigned rel_cnt  = 0;
  int unsigned n_pop1   = 0;
  int unsigned n_pop2   = 0;
  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] mdl [int unsigned];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_rd(input logic [9:0] a);
    return mdl.exists(int'(a)) ? mdl[int'(a)] : 32'h0;
  endfunction

  function automatic void mdl_wr(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    w = mdl_rd(a);
    for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
    mdl[int'(a)] = w;
  endfunction

  function automatic logic bench_collide();
    return s1_bus.chipselect && s1_bus.write && s2_bus.chipselect && s2_bus.write &&
           (s1_bus.address == s2_bus.address);
  endfunction

  // Reference model: evaluates acceptance at each edge, reads before writes
  always @(posedge clk) begin
    logic ok;
    logic coll;
    logic a1;
    logic a2;
    ok = (rel_cnt >= 2);
    if (!reset_n) begin
      rel_cnt = 0;
      q1.delete();
      q2.delete();
    end else if (rel_cnt < 2) begin
      rel_cnt++;
    end
    if (clken) ecnt++;
    coll = bench_collide();
    a1 = reset_n && ok && clken && s1_bus.chipselect && (s1_bus.read || s1_bus.write);
    a2 = reset_n && ok && clken && s2_bus.chipselect && (s2_bus.read || s2_bus.write) && !coll;
    if (a1 && s1_bus.read && !s1_bus.write) q1.push_back('{mdl_rd(s1_bus.address), ecnt});
    if (a2 && s2_bus.read && !s2_bus.write) q2.push_back('{mdl_rd(s2_bus.address), ecnt});
    if (a1 && s1_bus.write && !freeze) mdl_wr(s1_bus.address, s1_bus.byteenable, s1_bus.writedata);
    if (a2 && s2_bus.write && !freeze) mdl_wr(s2_bus.address, s2_bus.byteenable, s2_bus.writedata);
  end

  // Output monitor: mid-cycle sampling, results consumed on enabled cycles
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      check_eq("rst_s1_valid", {31'd0, s1_bus.readdatavalid}, 32'd0);
      check_eq("rst_s2_valid", {31'd0, s2_bus.readdatavalid}, 32'd0);
      check_eq("rst_s1_rdata", s1_bus.readdata, 32'd0);
      check_eq("rst_s2_rdata", s2_bus.readdata, 32'd0);
      check_eq("rst_s2_wait",  {31'd0, s2_bus.waitrequest}, 32'd0);
    end else begin
      check_eq("s2_waitrequest", {31'd0, s2_bus.waitrequest}, {31'd0, bench_collide()});
      check_eq("s1_waitrequest", {31'd0, s1_bus.waitrequest}, 32'd0);
`ifdef RAM_OUTREG_EN
      if (!s1_bus.readdatavalid) check_eq("s1_rdata_idle", s1_bus.readdata, 32'd0);
      if (!s2_bus.readdatavalid) check_eq("s2_rdata_idle", s2_bus.readdata, 32'd0);
`endif
      if (clken && s1_bus.readdatavalid) begin
        if (q1.size() == 0) begin
          check_eq("s1_spurious_valid", {31'd0, s1_bus.readdatavalid}, 32'd0);
        end else begin
          e = q1.pop_front();
          n_pop1++;
          check_eq("s1_rdata", s1_bus.readdata, e.data);
          check_eq("s1_latency", ecnt - e.ecnt, LAT - 1);
        end
      end
      if (clken && s2_bus.readdatavalid) begin
        if (q2.size() == 0) begin
          check_eq("s2_spurious_valid", {31'd0, s2_bus.readdatavalid}, 32'd0);
        end else begin
          e = q2.pop_front();
          n_pop2++;
          check_eq("s2_rdata", s2_bus.readdata, e.data);
          check_eq("s2_latency", ecnt - e.ecnt, LAT - 1);
        end
      end
    end
  end

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic s1_set(input logic r, input logic w, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    s1_bus.chipselect = r | w;
    s1_bus.read       = r;
    s1_bus.write      = w;
    s1_bus.address    = a;
    s1_bus.byteenable = be;
    s1_bus.writedata  = d;
  endtask

  task automatic s2_set(input logic r, input logic w, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    s2_bus.chipselect = r | w;
    s2_bus.read       = r;
    s2_bus.write      = w;
    s2_bus.address    = a;
    s2_bus.byteenable = be;
    s2_bus.writedata  = d;
  endtask

  task automatic idle();
    s1_set(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    s2_set(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int unsigned base1;
    int unsigned base2;
    logic        hold;
    int unsigned op;

    reset_n = 1'b0;
    clken   = 1'b1;
    freeze  = 1'b0;
    idle();
    tick(3);
    reset_n = 1'b1;
    tick(4);

    // Single write then read
    s1_set(1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF); tick();
    s1_set(1'b1, 1'b0, 10'd5, 4'h0, 32'h0);        tick();
    idle(); tick(3);

    // Byte lanes
    s1_set(1'b0, 1'b1, 10'd7, 4'hF, 32'h11223344); tick();
    s1_set(1'b0, 1'b1, 10'd7, 4'h5, 32'hAABBCCDD); tick();
    s1_set(1'b1, 1'b0, 10'd7, 4'h0, 32'h0);        tick();
    idle(); tick(3);

    // Same-address write collision
    s1_set(1'b0, 1'b1, 10'h3FF, 4'hF, 32'h1);
    s2_set(1'b0, 1'b1, 10'h3FF, 4'hF, 32'h2);
    #1 check_eq("collide_wait_hi", {31'd0, s2_bus.waitrequest}, 32'd1);
    tick();
    s1_set(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    #1 check_eq("collide_wait_lo", {31'd0, s2_bus.waitrequest}, 32'd0);
    tick();
    idle();
    s1_set(1'b1, 1'b0, 10'h3FF, 4'h0, 32'h0); tick();
    idle(); tick(3);

    // Cross-port read-during-write, both directions
    s1_set(1'b0, 1'b1, 10'd9, 4'hF, 32'hA); tick();
    s1_set(1'b0, 1'b1, 10'd9, 4'hF, 32'hB);
    s2_set(1'b1, 1'b0, 10'd9, 4'h0, 32'h0); tick();
    s1_set(1'b1, 1'b0, 10'd9, 4'h0, 32'h0);
    s2_set(1'b0, 1'b1, 10'd9, 4'hF, 32'hC); tick();
    s1_set(1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    s2_set(1'b1, 1'b0, 10'd9, 4'h0, 32'h0); tick();
    idle(); tick(3);

    // Freeze discards writes
    s1_set(1'b0, 1'b1, 10'd1, 4'hF, 32'h0); tick();
    freeze = 1'b1;
    s1_set(1'b0, 1'b1, 10'd1, 4'hF, 32'hFFFFFFFF); tick();
    freeze = 1'b0;
    s1_set(1'b1, 1'b0, 10'd1, 4'h0, 32'h0); tick();
    idle(); tick(3);

    // Back-to-back reads with a clock-enable gap
    for (int unsigned i = 0; i < 4; i++) begin
      s1_set(1'b0, 1'b1, 10'(20 + i), 4'hF, 32'h100 + i);
      s2_set(1'b0, 1'b1, 10'(30 + i), 4'hF, 32'h200 + i);
      tick();
    end
    base1 = n_pop1;
    base2 = n_pop2;
    for (int unsigned i = 0; i < 4; i++) begin
      s1_set(1'b1, 1'b0, 10'(20 + i), 4'h0, 32'h0);
      s2_set(1'b1, 1'b0, 10'(30 + i), 4'h0, 32'h0);
      if (i == 2) begin
        clken = 1'b0;
        tick(3);
        clken = 1'b1;
      end
      tick();
    end
    idle(); tick(4);
    check_eq("s1_burst_count", n_pop1 - base1, 32'd4);
    check_eq("s2_burst_count", n_pop2 - base2, 32'd4);

    // Random mixed traffic over a small address window
    for (int unsigned i = 0; i < 8; i++) begin
      s1_set(1'b0, 1'b1, 10'(40 + i), 4'hF, $urandom);
      tick();
    end
    idle();
    hold = 1'b0;
    repeat (300) begin
      op = $urandom_range(0, 3);
      s1_set(op[0], op[1], 10'(40 + $urandom_range(0, 7)), 4'($urandom), $urandom);
      if (!hold) begin
        op = $urandom_range(0, 3);
        s2_set(op[0], op[1], 10'(40 + $urandom_range(0, 7)), 4'($urandom), $urandom);
      end
      clken  = ($urandom_range(0, 7) != 0);
      freeze = ($urandom_range(0, 15) == 0);
      hold   = bench_collide();
      tick();
    end
    idle();
    clken  = 1'b1;
    freeze = 1'b0;
    tick(5);

    // Reset one cycle into an accepted read
    s1_set(1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
    s2_set(1'b1, 1'b0, 10'd9, 4'h0, 32'h0);
    tick();
    reset_n = 1'b0;
    idle();
    #1;
    check_eq("midrst_s1_valid", {31'd0, s1_bus.readdatavalid}, 32'd0);
    check_eq("midrst_s2_valid", {31'd0, s2_bus.readdatavalid}, 32'd0);
    check_eq("midrst_s1_rdata", s1_bus.readdata, 32'd0);
    check_eq("midrst_s2_rdata", s2_bus.readdata, 32'd0);
    tick(3);
    reset_n = 1'b1;
    tick(4);
    s1_set(1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
    s2_set(1'b1, 1'b0, 10'd9, 4'h0, 32'h0);
    tick();
    s1_set(1'b1, 1'b0, 10'd7, 4'h0, 32'h0);
    s2_set(1'b1, 1'b0, 10'h3FF, 4'h0, 32'h0);
    tick();
    idle(); tick(6);

    check_eq("s1_pending", q1.size(), 32'd0);
    check_eq("s2_pending", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
